link_rx: RTL

Parametrised receiver for the board-to-board keyboard/health link: it samples a strobed parallel pin bus and reassembles a DATA_W-bit word from SLICE_W-bit slices. It extends the fixed 12-bit, two-slice receiver with four additions: a generic slice count, an explicit slice index, per-slice even parity, and sequence checking. It also provides a frame-valid pulse, an error counter and link-alive supervision. It sits directly behind the inter-board pin header and feeds decoded words to the application logic.

---
 rtl/link_rx.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/link_rx.sv
// Board-to-board link receiver: samples a strobed pin bus and reassembles
// DATA_W-bit words from indexed, parity-protected SLICE_W-bit slices.
module link_rx #(
    parameter int unsigned DATA_W       = 12,
    parameter int unsigned SLICE_W      = 6,
    parameter int unsigned SAMPLE_DELAY = 1000,
    parameter int unsigned TIMEOUT      = 1_000_000,
    parameter int unsigned ERR_W        = 8,
    localparam int unsigned NSLICE = DATA_W / SLICE_W,
    localparam int unsigned IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1,
    localparam int unsigned PIN_W  = 2 + IDX_W + SLICE_W
) (
    input  logic              rx_clk,
    input  logic              rst_n,
    input  logic [PIN_W-1:0]  rx_pins,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              parity_err,
    output logic              seq_err,
    output logic [ERR_W-1:0]  err_count,
    output logic              link_up
);

    localparam int unsigned CNT_W = (SAMPLE_DELAY > 1) ? $clog2(SAMPLE_DELAY) : 1;
    localparam int unsigned WD_W  = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, DELAY, SAMPLE, CHECK} state_t;

    state_t              state, state_nxt;
    logic [PIN_W-1:0]    sync1, sync2;
    logic                strobe_prev;
    logic                rise_c;
    logic [CNT_W-1:0]    cnt, cnt_nxt;
    logic [WD_W-1:0]     wd, wd_nxt;
    logic [SLICE_W-1:0]  cap_slice, cap_slice_nxt;
    logic [IDX_W-1:0]    cap_idx, cap_idx_nxt;
    logic                cap_par, cap_par_nxt;
    logic [IDX_W-1:0]    expected, expected_nxt;
    logic [DATA_W-1:0]   asm_word, asm_nxt, asm_ins;
    logic [DATA_W-1:0]   dout_nxt;
    logic                dv_nxt, pe_nxt, se_nxt, link_nxt, err_evt;
    logic [ERR_W-1:0]    err_nxt;

    assign rise_c = sync2[0] & ~strobe_prev;

    // Partial word with the captured slice dropped into its lane
    always_comb begin
        asm_ins = asm_word;
        for (int i = 0; i < int'(NSLICE); i++) begin
            if (cap_idx == IDX_W'(i))
                asm_ins[DATA_W-1-i*SLICE_W -: SLICE_W] = cap_slice;
        end
    end

    always_ff @(posedge rx_clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        wd_nxt        = wd;
        cap_slice_nxt = cap_slice;
        cap_idx_nxt   = cap_idx;
        cap_par_nxt   = cap_par;
        expected_nxt  = expected;
        asm_nxt       = asm_word;
        dout_nxt      = data_out;
        dv_nxt        = 1'b0;
        pe_nxt        = 1'b0;
        se_nxt        = 1'b0;
        link_nxt      = link_up;
        err_evt       = 1'b0;
        err_nxt       = err_count;

        if (rise_c)                      wd_nxt = '0;
        else if (wd != WD_W'(TIMEOUT))   wd_nxt = WD_W'(wd + 1'b1);

        case (state)
            IDLE: begin
                if (rise_c) begin
                    cnt_nxt   = '0;
                    state_nxt = DELAY;
                end
            end
            DELAY: begin
                cnt_nxt = CNT_W'(cnt + 1'b1);
                if (cnt == CNT_W'(SAMPLE_DELAY - 1)) state_nxt = SAMPLE;
            end
            SAMPLE: begin
                cap_slice_nxt = sync2[SLICE_W:1];
                cap_idx_nxt   = sync2[SLICE_W+IDX_W:SLICE_W+1];
                cap_par_nxt   = sync2[PIN_W-1];
                state_nxt     = CHECK;
            end
            CHECK: begin
                state_nxt = IDLE;
                if (^{cap_par, cap_idx, cap_slice}) begin
                    pe_nxt       = 1'b1;
                    err_evt      = 1'b1;
                    expected_nxt = '0;
                end else if (cap_idx != expected) begin
                    se_nxt  = 1'b1;
                    err_evt = 1'b1;
                    if (cap_idx == '0) begin
                        asm_nxt = asm_ins;
                        if (NSLICE == 1) begin
                            dout_nxt     = asm_ins;
                            dv_nxt       = 1'b1;
                            expected_nxt = '0;
                            link_nxt     = 1'b1;
                        end else begin
                            expected_nxt = IDX_W'(1);
                        end
                    end else begin
                        expected_nxt = '0;
                    end
                end else begin
                    asm_nxt = asm_ins;
                    if (cap_idx == IDX_W'(NSLICE - 1)) begin
                        dout_nxt     = asm_ins;
                        dv_nxt       = 1'b1;
                        expected_nxt = '0;
                        link_nxt     = 1'b1;
                    end else begin
                        expected_nxt = IDX_W'(expected + 1'b1);
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (err_evt && (err_count != {ERR_W{1'b1}}))
            err_nxt = ERR_W'(err_count + 1'b1);

        // Watchdog expiry drops the link and forces a fresh frame start
        if (!rise_c && (wd == WD_W'(TIMEOUT - 1))) begin
            link_nxt     = 1'b0;
            expected_nxt = '0;
        end
    end

    always_ff @(posedge rx_clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1       <= '0;
            sync2       <= '0;
            strobe_prev <= 1'b0;
            cnt         <= '0;
            wd          <= '0;
            cap_slice   <= '0;
            cap_idx     <= '0;
            cap_par     <= 1'b0;
            expected    <= '0;
            asm_word    <= '0;
            data_out    <= '0;
            data_valid  <= 1'b0;
            parity_err  <= 1'b0;
            seq_err     <= 1'b0;
            err_count   <= '0;
            link_up     <= 1'b0;
        end else begin
            sync1       <= rx_pins;
            sync2       <= sync1;
            strobe_prev <= sync2[0];
            cnt         <= cnt_nxt;
            wd          <= wd_nxt;
            cap_slice   <= cap_slice_nxt;
            cap_idx     <= cap_idx_nxt;
            cap_par     <= cap_par_nxt;
            expected    <= expected_nxt;
            asm_word    <= asm_nxt;
            data_out    <= dout_nxt;
            data_valid  <= dv_nxt;
            parity_err  <= pe_nxt;
            seq_err     <= se_nxt;
            err_count   <= err_nxt;
            link_up     <= link_nxt;
        end
    end

endmodule
